// File: rtl/bsg_tx_sequencer.sv
// Transmit sequencer: two-slot ping-pong buffer drained in strict slot order to the modulator.
// Optional handshake counter port tx_count is built only when BSG_TX_CNT_EN is defined.
module bsg_tx_sequencer #(
  parameter int DATA_W = 8
`ifdef BSG_TX_CNT_EN
  , parameter int COUNT_W = 16
`endif
) (
  input  logic              G_CLK_TX,
  input  logic              reset,
  input  logic              tx_enable,
  input  logic              int_mask,
  input  logic              int_clear,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  output logic [1:0]        slot_free,
  output logic [DATA_W-1:0] mod_data,
  output logic              mod_valid,
  input  logic              mod_ready,
  output logic              int_flag,
  output logic              irq,
  output logic              status,
  output logic              overrun
`ifdef BSG_TX_CNT_EN
  , output logic [COUNT_W-1:0] tx_count
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [DATA_W-1:0] slot_data [2];
  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic              ptr;
  logic              handshake;
  logic              wr_accept;
  logic              wr_reject;

  assign handshake = mod_valid & mod_ready;
  assign wr_accept = wr_en & ~full[wr_sel];
  assign wr_reject = wr_en & full[wr_sel];

  // A slot being drained this cycle is still seen as full by a same-cycle write.
  always_comb begin
    full_nxt = full;
    if (handshake) full_nxt[ptr] = 1'b0;
    if (wr_accept) full_nxt[wr_sel] = 1'b1;
  end

  always_ff @(posedge G_CLK_TX or posedge reset) begin
    if (reset) begin
      slot_data[0] <= '0;
      slot_data[1] <= '0;
    end else if (wr_accept) begin
      slot_data[wr_sel] <= wr_data;
    end
  end

  always_ff @(posedge G_CLK_TX or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      full      <= 2'b00;
      mod_data  <= '0;
      mod_valid <= 1'b0;
      int_flag  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      full <= full_nxt;

      case (state)
        IDLE: begin
          if (tx_enable && full[ptr]) begin
            mod_data  <= slot_data[ptr];
            mod_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // Once presented, a word is held until accepted; tx_enable only gates the next one.
          if (handshake) begin
            ptr <= ~ptr;
            if (tx_enable && full[~ptr]) begin
              mod_data <= slot_data[~ptr];
            end else begin
              mod_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          mod_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase

      if (handshake && (full_nxt == 2'b00)) int_flag <= 1'b1;
      else if (int_clear)                   int_flag <= 1'b0;

      if (wr_reject)      overrun <= 1'b1;
      else if (int_clear) overrun <= 1'b0;
    end
  end

`ifdef BSG_TX_CNT_EN
  always_ff @(posedge G_CLK_TX or posedge reset) begin
    if (reset)          tx_count <= '0;
    else if (handshake) tx_count <= tx_count + COUNT_W'(1);
  end
`endif

  assign slot_free = ~full;
  assign irq       = int_flag & ~int_mask;
  assign status    = (state == SEND) | ~&slot_free;

endmodule

// File: tb/tb_bsg_tx_sequencer.sv
// Randomized and directed bench for bsg_tx_sequencer against a slot/word-level reference model.
// Define BSG_TX_CNT_EN to also exercise tx_count (DUT built with a narrow counter to reach wrap quickly).
module tb_bsg_tx_sequencer;

  localparam int DATA_W = 8;
`ifdef BSG_TX_CNT_EN
  localparam int CW = 4;
  logic [CW-1:0] tx_count;
`endif

  logic              G_CLK_TX;
  logic              reset;
  logic              tx_enable;
  logic              int_mask;
  logic              int_clear;
  logic              wr_en;
  logic              wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        slot_free;
  logic [DATA_W-1:0] mod_data;
  logic              mod_valid;
  logic              mod_ready;
  logic              int_flag;
  logic              irq;
  logic              status;
  logic              overrun;

  int total;
  int bad;

  // reference model: two buffered words, which slot is next in line, and the word on offer
  bit [1:0]          m_full;
  logic [DATA_W-1:0] m_slot [2];
  bit                m_next;
  bit                m_busy;
  logic [DATA_W-1:0] m_word;
  bit                m_flag;
  bit                m_ovr;
  int                m_sent;

  bsg_tx_sequencer #(
    .DATA_W(DATA_W)
`ifdef BSG_TX_CNT_EN
    , .COUNT_W(CW)
`endif
  ) dut (
    .G_CLK_TX (G_CLK_TX),
    .reset    (reset),
    .tx_enable(tx_enable),
    .int_mask (int_mask),
    .int_clear(int_clear),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .slot_free(slot_free),
    .mod_data (mod_data),
    .mod_valid(mod_valid),
    .mod_ready(mod_ready),
    .int_flag (int_flag),
    .irq      (irq),
    .status   (status),
    .overrun  (overrun)
`ifdef BSG_TX_CNT_EN
    , .tx_count(tx_count)
`endif
  );

  initial G_CLK_TX = 1'b0;
  always #5 G_CLK_TX = ~G_CLK_TX;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_full  = 2'b00;
    m_slot[0] = '0;
    m_slot[1] = '0;
    m_next  = 1'b0;
    m_busy  = 1'b0;
    m_word  = '0;
    m_flag  = 1'b0;
    m_ovr   = 1'b0;
    m_sent  = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    bit       accepted;
    bit       ovr_hit;
    bit [1:0] after;
    accepted = m_busy && mod_ready;
    ovr_hit  = wr_en && m_full[wr_sel];
    after    = m_full;
    if (wr_en && !m_full[wr_sel]) after[wr_sel] = 1'b1;
    if (accepted) after[m_next] = 1'b0;

    if (!m_busy) begin
      if (tx_enable && m_full[m_next]) begin
        m_busy = 1'b1;
        m_word = m_slot[m_next];
      end
    end else if (accepted) begin
      m_sent++;
      m_next = !m_next;
      if (tx_enable && m_full[m_next]) m_word = m_slot[m_next];
      else m_busy = 1'b0;
    end

    if (wr_en && !m_full[wr_sel]) m_slot[wr_sel] = wr_data;

    if (accepted && after == 2'b00) m_flag = 1'b1;
    else if (int_clear)            m_flag = 1'b0;
    if (ovr_hit)        m_ovr = 1'b1;
    else if (int_clear) m_ovr = 1'b0;
    m_full = after;
  endtask

  task automatic checkAll();
    logic [1:0] exp_free;
    logic       exp_irq;
    logic       exp_status;
    exp_free   = ~m_full;
    exp_irq    = m_flag & ~int_mask;
    exp_status = m_busy | (m_full != 2'b00);
    checkOutput("mod_valid", {31'b0, mod_valid}, {31'b0, m_busy});
    checkOutput("mod_data",  {24'b0, mod_data},  {24'b0, m_word});
    checkOutput("slot_free", {30'b0, slot_free}, {30'b0, exp_free});
    checkOutput("int_flag",  {31'b0, int_flag},  {31'b0, m_flag});
    checkOutput("irq",       {31'b0, irq},       {31'b0, exp_irq});
    checkOutput("status",    {31'b0, status},    {31'b0, exp_status});
    checkOutput("overrun",   {31'b0, overrun},   {31'b0, m_ovr});
`ifdef BSG_TX_CNT_EN
    checkOutput("tx_count",  {28'b0, tx_count},  32'(m_sent % (1 << CW)));
`endif
  endtask

  task automatic applyStimulus(input bit te, input bit im, input bit ic, input bit we,
                               input bit ws, input logic [DATA_W-1:0] wd, input bit mr);
    @(negedge G_CLK_TX);
    tx_enable = te;
    int_mask  = im;
    int_clear = ic;
    wr_en     = we;
    wr_sel    = ws;
    wr_data   = wd;
    mod_ready = mr;
    modelStep();
    @(posedge G_CLK_TX);
    #1;
    checkAll();
  endtask

  // Reset is raised mid-cycle so its asynchronous effect is visible before any clock edge.
  task automatic doReset();
    @(negedge G_CLK_TX);
    reset     = 1'b1;
    tx_enable = 1'b0;
    int_mask  = 1'b0;
    int_clear = 1'b0;
    wr_en     = 1'b0;
    wr_sel    = 1'b0;
    wr_data   = '0;
    mod_ready = 1'b0;
    modelReset();
    #1;
    checkAll();
    checkOutput("rst_slot_free", {30'b0, slot_free}, 32'h3);
    #3;
    reset = 1'b0;
  endtask

  initial begin
    int writes;
    int guard;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    tx_enable = 1'b0; int_mask = 1'b0; int_clear = 1'b0;
    wr_en = 1'b0; wr_sel = 1'b0; wr_data = '0; mod_ready = 1'b0;
    modelReset();
    #12;
    doReset();

    // reset while a word is on offer
    applyStimulus(1, 0, 0, 1, 0, 8'hE7, 0);
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 0);
    checkOutput("pre_rst_valid", {31'b0, mod_valid}, 32'h1);
    doReset();
    checkOutput("rst_mod_valid", {31'b0, mod_valid}, 32'h0);

    // back-to-back drain, interrupt set wins over same-cycle clear
    applyStimulus(1, 0, 0, 1, 0, 8'hA5, 1);
    applyStimulus(1, 0, 0, 1, 1, 8'h3C, 1);
    checkOutput("b2b_first", {24'b0, mod_data}, 32'hA5);
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 1);
    checkOutput("b2b_second", {24'b0, mod_data}, 32'h3C);
    checkOutput("b2b_valid", {31'b0, mod_valid}, 32'h1);
    applyStimulus(1, 0, 1, 0, 0, 8'h00, 1);
    checkOutput("flag_set_wins", {31'b0, int_flag}, 32'h1);
    checkOutput("irq_unmasked", {31'b0, irq}, 32'h1);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 0);
    checkOutput("irq_masked", {31'b0, irq}, 32'h0);
    applyStimulus(0, 0, 1, 0, 0, 8'h00, 0);
    checkOutput("flag_cleared", {31'b0, int_flag}, 32'h0);

    // stall with tx_enable dropped mid-word
    applyStimulus(0, 0, 0, 1, 0, 8'h5A, 0);
    applyStimulus(0, 0, 0, 1, 1, 8'hC3, 0);
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i < 2, 0, 0, 0, 0, 8'h00, 0);
      checkOutput("stall_data", {24'b0, mod_data}, 32'h5A);
      checkOutput("stall_valid", {31'b0, mod_valid}, 32'h1);
    end
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 1);
    checkOutput("stall_done_valid", {31'b0, mod_valid}, 32'h0);
    checkOutput("stall_slot1_kept", {30'b0, slot_free}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 1);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 1);
    checkOutput("stall_no_resend", {31'b0, mod_valid}, 32'h0);

    // overrun on a full slot keeps the old word
    applyStimulus(0, 0, 0, 1, 0, 8'h77, 0);
    applyStimulus(0, 0, 0, 1, 0, 8'h11, 0);
    checkOutput("overrun_set", {31'b0, overrun}, 32'h1);
    applyStimulus(0, 0, 1, 0, 0, 8'h00, 0);
    checkOutput("overrun_clr", {31'b0, overrun}, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 1);
    checkOutput("order_slot1", {24'b0, mod_data}, 32'hC3);
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 1);
    checkOutput("old_word_kept", {24'b0, mod_data}, 32'h77);
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 1);
    applyStimulus(0, 0, 1, 0, 0, 8'h00, 0);

    // strict order: slot 1 alone does not start while slot 0 is next
    doReset();
    applyStimulus(1, 0, 0, 1, 1, 8'h99, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 8'h00, 1);
      checkOutput("strict_wait", {31'b0, mod_valid}, 32'h0);
    end
    applyStimulus(1, 0, 0, 1, 0, 8'h42, 1);
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 1);
    checkOutput("strict_first", {24'b0, mod_data}, 32'h42);
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 1);
    checkOutput("strict_second", {24'b0, mod_data}, 32'h99);
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 1);

`ifdef BSG_TX_CNT_EN
    // 2^CW + 3 handshakes wrap the counter to 3
    doReset();
    writes = 0;
    guard  = 0;
    while (writes < (1 << CW) + 3 && guard < 400) begin
      if (m_full != 2'b11) begin
        applyStimulus(1, 0, 0, 1, m_full[0], DATA_W'($urandom), 1);
        writes++;
      end else begin
        applyStimulus(1, 0, 0, 0, 0, 8'h00, 1);
      end
      guard++;
    end
    guard = 0;
    while ((m_busy || m_full != 2'b00) && guard < 20) begin
      applyStimulus(1, 0, 0, 0, 0, 8'h00, 1);
      guard++;
    end
    if (guard >= 20) checkOutput("cnt_drain_timeout", 32'h1, 32'h0);
    checkOutput("cnt_wrap", {28'b0, tx_count}, 32'h3);
`else
    writes = 0;
    guard  = 0;
`endif

    // randomized traffic
    doReset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
                      $urandom_range(0, 1) == 1, DATA_W'($urandom),
                      $urandom_range(0, 2) != 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
